slicer_pam_adapt: RTL and testbench

Registered, decision-directed adaptive PAM slicer. It supports PAM4 and PAM2 modes, selected at runtime. Instead of fixed levels it tracks the inner and outer symbol magnitudes with LMS-style accumulators, and derives the outer threshold from those levels. It sits after the FFE/DFE sum node and feeds the symbol demapper and the error input of the equaliser adaptation.

---
 rtl/slicer_pam_adapt.sv | 135 +++++++++++++
 tb/tb_slicer_pam_adapt.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/slicer_pam_adapt.sv
// Decision-directed adaptive PAM2/PAM4 slicer with LMS tracking of the inner
// and outer symbol magnitudes; decisions, Gray symbol and slicer error are registered.
module slicer_pam_adapt #(
  parameter int NB       = 8,
  parameter int NBF      = 7,
  parameter int NB_ACC   = 16,
  parameter int MU_SHIFT = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic signed [NB-1:0] i_sample,
  input  logic                 i_mode,
  input  logic                 i_adapt_en,
  output logic                 o_valid,
  output logic signed [NB-1:0] o_slicer,
  output logic [1:0]           o_gray_level,
  output logic signed [NB:0]   o_error,
  output logic [NB-1:0]        o_level_inner,
  output logic [NB-1:0]        o_level_outer
);

  localparam int LVL_LSB = NB_ACC - NB;
  localparam int SH      = NB_ACC - NB - MU_SHIFT;
  localparam logic [NB_ACC-1:0] ACC_IN_RST  = NB_ACC'(1) << (NBF - 2 + LVL_LSB);
  localparam logic [NB_ACC-1:0] ACC_OUT_RST = NB_ACC'(3) << (NBF - 2 + LVL_LSB);
  localparam logic [NB_ACC-1:0] ACC_MAX     = {1'b0, {(NB_ACC-1){1'b1}}};

  // |v| with the most negative code pinned to the largest positive code
  function automatic logic [NB-1:0] sat_abs(input logic signed [NB-1:0] v);
    if (v == {1'b1, {(NB-1){1'b0}}})
      return {1'b0, {(NB-1){1'b1}}};
    else if (v < 0)
      return -v;
    else
      return v;
  endfunction

  // Keeps the accumulator inside the non-negative half so levels stay positive
  function automatic logic [NB_ACC-1:0] clamp_acc(input logic signed [NB_ACC+1:0] v);
    if (v < 0)
      return '0;
    else if (v > $signed({2'b00, ACC_MAX}))
      return ACC_MAX;
    else
      return v[NB_ACC-1:0];
  endfunction

  logic                 vld_p0;
  logic signed [NB-1:0] slicer_p0;
  logic [1:0]           gray_p0;
  logic signed [NB:0]   err_p0;
  logic [NB_ACC-1:0]    acc_in_p0;
  logic [NB_ACC-1:0]    acc_out_p0;

  logic signed [NB-1:0]     l1_n, l3_n, dec_w;
  logic signed [NB:0]       x_w, l1_w, l3_w, th_w, err_w, lsel_w, e_w;
  logic [1:0]               gray_w;
  logic                     outer_w;
  logic [NB-1:0]            mag_w;
  logic [NB_ACC-1:0]        acc_sel_w;
  logic signed [NB_ACC+1:0] step_w, acc_sum_w;

  assign l1_n = acc_in_p0[NB_ACC-1 -: NB];
  assign l3_n = acc_out_p0[NB_ACC-1 -: NB];
  assign l1_w = {1'b0, l1_n};
  assign l3_w = {1'b0, l3_n};
  assign x_w  = {i_sample[NB-1], i_sample};
  assign th_w = (l1_w + l3_w) >>> 1;

  always_comb begin
    dec_w   = l3_n;
    gray_w  = 2'b10;
    outer_w = 1'b1;
    if (i_mode) begin
      if (x_w < -th_w) begin
        dec_w  = -l3_n;
        gray_w = 2'b00;
      end else if (x_w < 0) begin
        dec_w   = -l1_n;
        gray_w  = 2'b01;
        outer_w = 1'b0;
      end else if (x_w < th_w) begin
        dec_w   = l1_n;
        gray_w  = 2'b11;
        outer_w = 1'b0;
      end
    end else if (x_w < 0) begin
      dec_w  = -l3_n;
      gray_w = 2'b00;
    end
  end

  assign err_w     = x_w - {dec_w[NB-1], dec_w};
  assign mag_w     = sat_abs(i_sample);
  assign lsel_w    = outer_w ? l3_w : l1_w;
  assign e_w       = $signed({1'b0, mag_w}) - lsel_w;
  assign step_w    = $signed({{(NB_ACC+1-NB){e_w[NB]}}, e_w}) <<< SH;
  assign acc_sel_w = outer_w ? acc_out_p0 : acc_in_p0;
  assign acc_sum_w = $signed({2'b00, acc_sel_w}) + step_w;

  // Stage p0: registered decision and level update
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      vld_p0     <= 1'b0;
      slicer_p0  <= '0;
      gray_p0    <= 2'b00;
      err_p0     <= '0;
      acc_in_p0  <= ACC_IN_RST;
      acc_out_p0 <= ACC_OUT_RST;
    end else if (i_enable) begin
      vld_p0 <= i_valid;
      if (i_valid) begin
        slicer_p0 <= dec_w;
        gray_p0   <= gray_w;
        err_p0    <= err_w;
        if (i_adapt_en) begin
          if (outer_w)
            acc_out_p0 <= clamp_acc(acc_sum_w);
          else
            acc_in_p0  <= clamp_acc(acc_sum_w);
        end
      end
    end
  end

  assign o_valid       = vld_p0;
  assign o_slicer      = slicer_p0;
  assign o_gray_level  = gray_p0;
  assign o_error       = err_p0;
  assign o_level_inner = acc_in_p0[NB_ACC-1 -: NB];
  assign o_level_outer = acc_out_p0[NB_ACC-1 -: NB];

endmodule

// File: tb/tb_slicer_pam_adapt.sv
// Directed bench for slicer_pam_adapt: reset, PAM4/PAM2 decisions, hold,
// adaptation, clamp/convergence and mid-stream mode switching.
module tb_slicer_pam_adapt;

  logic              i_clock = 1'b0;
  logic              i_reset;
  logic              i_enable;
  logic              i_valid;
  logic signed [7:0] i_sample;
  logic              i_mode;
  logic              i_adapt_en;
  logic              o_valid;
  logic signed [7:0] o_slicer;
  logic [1:0]        o_gray_level;
  logic signed [8:0] o_error;
  logic [7:0]        o_level_inner;
  logic [7:0]        o_level_outer;

  int n_pass  = 0;
  int n_total = 0;

  slicer_pam_adapt #(.NB(8), .NBF(7), .NB_ACC(16), .MU_SHIFT(6)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_valid       (i_valid),
    .i_sample      (i_sample),
    .i_mode        (i_mode),
    .i_adapt_en    (i_adapt_en),
    .o_valid       (o_valid),
    .o_slicer      (o_slicer),
    .o_gray_level  (o_gray_level),
    .o_error       (o_error),
    .o_level_inner (o_level_inner),
    .o_level_outer (o_level_outer)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic v, input int s, input logic m, input logic a);
    i_valid    = v;
    i_sample   = 8'(s);
    i_mode     = m;
    i_adapt_en = a;
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk_dec(input string tag, input int slc, input int gray, input int err);
    chk({tag, "_valid"}, 32'(o_valid), 1);
    chk({tag, "_slicer"}, 32'($signed(o_slicer)), slc);
    chk({tag, "_gray"}, 32'(o_gray_level), gray);
    chk({tag, "_error"}, 32'($signed(o_error)), err);
  endtask

  int   p4_s[5] = '{-70, -10, 0, 63, 64};
  int   p4_y[5] = '{-96, -32, 32, 32, 96};
  int   p4_g[5] = '{0, 1, 3, 3, 2};
  int   p4_e[5] = '{26, 22, -32, 31, -32};
  int   p2_s[4] = '{-1, 0, 127, -128};
  int   p2_y[4] = '{-96, 96, 96, -96};
  int   p2_g[4] = '{0, 2, 2, 0};
  int   p2_e[4] = '{95, -96, 31, -32};
  int   prev;
  logic wrapped;

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0;
    i_sample = '0; i_mode = 1'b1; i_adapt_en = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_slicer", 32'($signed(o_slicer)), 0);
    chk("rst_gray", 32'(o_gray_level), 0);
    chk("rst_error", 32'($signed(o_error)), 0);
    chk("rst_l1", 32'(o_level_inner), 32);
    chk("rst_l3", 32'(o_level_outer), 96);
    i_reset = 1'b0;

    // PAM4 decisions with fixed levels
    for (int i = 0; i < 5; i++) begin
      step(1'b1, p4_s[i], 1'b1, 1'b0);
      chk_dec($sformatf("pam4_%0d", i), p4_y[i], p4_g[i], p4_e[i]);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    chk("idle_valid", 32'(o_valid), 0);
    chk("idle_slicer_hold", 32'($signed(o_slicer)), 96);

    // PAM2 decisions
    for (int i = 0; i < 4; i++) begin
      step(1'b1, p2_s[i], 1'b0, 1'b0);
      chk_dec($sformatf("pam2_%0d", i), p2_y[i], p2_g[i], p2_e[i]);
    end
    chk("noadapt_l1", 32'(o_level_inner), 32);
    chk("noadapt_l3", 32'(o_level_outer), 96);

    // Clock enable low: everything holds, o_valid included
    i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 127, 1'b1, 1'b1);
      chk("hold_valid", 32'(o_valid), 1);
      chk("hold_slicer", 32'($signed(o_slicer)), -96);
      chk("hold_l3", 32'(o_level_outer), 96);
    end
    i_enable = 1'b1;

    // Adaptation on the outer level, idle cycles interleaved
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 80, 1'b1, 1'b1);
      chk("adapt_slicer", 32'($signed(o_slicer)), (i == 0) ? 96 : 95);
      chk("adapt_l3", 32'(o_level_outer), 95);
      step(1'b0, 80, 1'b1, 1'b1);
      chk("adapt_idle_valid", 32'(o_valid), 0);
      chk("adapt_idle_l3", 32'(o_level_outer), 95);
    end
    chk("adapt_l1", 32'(o_level_inner), 32);

    // Long run of full-scale positive samples
    wrapped = 1'b0;
    prev = int'(o_level_outer);
    for (int i = 0; i < 800; i++) begin
      step(1'b1, 127, 1'b1, 1'b1);
      if (int'(o_level_outer) < prev) wrapped = 1'b1;
      prev = int'(o_level_outer);
    end
    chk("conv_l3", 32'(o_level_outer), 127);
    chk("conv_l3_nowrap", 32'(wrapped), 0);
    chk("conv_l1_untouched", 32'(o_level_inner), 32);

    // Long run of zeros drives L1 to zero
    for (int i = 0; i < 800; i++) step(1'b1, 0, 1'b1, 1'b1);
    chk("decay_l1", 32'(o_level_inner), 0);
    chk("decay_l3", 32'(o_level_outer), 127);
    chk_dec("zero_at_l1_0", 0, 3, 0);
    step(1'b1, -128, 1'b1, 1'b1);
    chk_dec("min_sample", -127, 0, -1);
    chk("min_sample_l3", 32'(o_level_outer), 127);
    chk("min_sample_l1", 32'(o_level_inner), 0);

    // Asynchronous reset in the middle of a valid stream
    i_valid = 1'b1; i_sample = 8'sd127; i_adapt_en = 1'b1;
    i_reset = 1'b1;
    #1;
    chk("midrst_async_valid", 32'(o_valid), 0);
    chk("midrst_async_l1", 32'(o_level_inner), 32);
    chk("midrst_async_l3", 32'(o_level_outer), 96);
    @(posedge i_clock);
    #1;
    chk("midrst_valid", 32'(o_valid), 0);
    chk("midrst_slicer", 32'($signed(o_slicer)), 0);
    i_reset = 1'b0;
    step(1'b1, 64, 1'b1, 1'b0);
    chk_dec("post_rst", 96, 2, -32);

    // Mode switch with adaptation running
    step(1'b1, 80, 1'b1, 1'b1);
    chk("sw_l3_a", 32'(o_level_outer), 95);
    step(1'b1, 10, 1'b1, 1'b1);
    chk_dec("sw_pam4_inner", 32, 3, -22);
    chk("sw_l1_a", 32'(o_level_inner), 31);
    step(1'b1, 10, 1'b0, 1'b1);
    chk_dec("sw_pam2_pos", 95, 2, -85);
    chk("sw_l3_b", 32'(o_level_outer), 94);
    chk("sw_l1_frozen_b", 32'(o_level_inner), 31);
    step(1'b1, -10, 1'b0, 1'b1);
    chk_dec("sw_pam2_neg", -94, 0, 84);
    chk("sw_l3_c", 32'(o_level_outer), 93);
    chk("sw_l1_frozen_c", 32'(o_level_inner), 31);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
